mio_bus_ctrl: RTL and testbench

- Memory/IO bus controller directly downstream of the multi-cycle CPU core.
- Accepts the core's request (CPU_MIO, mem_w, address, write data) and decodes the address to block RAM, 7-segment data register, switch/LED port or down-counter.
- Returns read data and a one-cycle MIO_ready completion pulse.
- Counter expiry drives the core's INT input.

---
 rtl/mio_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_mio_bus_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes core requests to block RAM, seg_data, sw/led and a down-counter.
// Latency: peripheral/unmapped MIO_ready 1 cycle after accept, RAM RAM_WAIT+2 cycles after accept.
// No backpressure: one transaction at a time, CPU_MIO ignored outside IDLE, completion is a one-cycle MIO_ready pulse.
module mio_bus_ctrl #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [31:0]       seg_data,
  output logic              INT
);

  typedef enum logic [1:0] {IDLE, RAMW, RESP} state_t;

  // Word addresses (byte address >> 2) of the memory-mapped registers
  localparam logic [29:0] SEG_WORD = 30'h3800_0000;
  localparam logic [29:0] SW_WORD  = 30'h3C00_0000;
  localparam logic [29:0] CNT_WORD = 30'h3C00_0001;
  localparam logic [29:0] INT_WORD = 30'h3C00_0002;
  localparam logic [2:0]  WAIT_INIT = 3'(RAM_WAIT);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        rd_q;
  logic [31:0] count;

  logic        accept;
  logic        hit_ram, hit_seg, hit_sw, hit_cnt, hit_int;
  logic        cnt_wr, int_clr;
  logic [31:0] per_rdata;
  logic        unused_addr_lsb;

  // Byte lane bits are meaningless for word-only accesses
  assign unused_addr_lsb = ^Addr_out[1:0];

  // Address decode and peripheral read mux, evaluated on the accept cycle
  always_comb begin
    accept    = (state == IDLE) && CPU_MIO;
    hit_ram   = (Addr_out[31:RAM_AW+2] == '0);
    hit_seg   = (Addr_out[31:2] == SEG_WORD);
    hit_sw    = (Addr_out[31:2] == SW_WORD);
    hit_cnt   = (Addr_out[31:2] == CNT_WORD);
    hit_int   = (Addr_out[31:2] == INT_WORD);
    cnt_wr    = accept && mem_w && hit_cnt;
    int_clr   = accept && mem_w && hit_int;
    per_rdata = 32'h0;
    if (hit_seg)      per_rdata = seg_data;
    else if (hit_sw)  per_rdata = {16'h0, sw};
    else if (hit_cnt) per_rdata = count;
    else if (hit_int) per_rdata = {31'h0, INT};
  end

  // Bus FSM: accepts a request, performs the register access or RAM cycle, then pulses MIO_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      rd_q      <= 1'b0;
      MIO_ready <= 1'b0;
      Data_in   <= 32'h0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      led       <= 16'h0;
      seg_data  <= 32'h0;
    end else begin
      // MIO_ready follows the RESP state by one edge so it lands in the cycle after RESP
      MIO_ready <= (state == RESP);
      ram_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (CPU_MIO) begin
            rd_q <= !mem_w;
            if (hit_ram) begin
              ram_addr  <= Addr_out[RAM_AW+1:2];
              ram_wdata <= Data_out;
              ram_we    <= mem_w;
              wait_cnt  <= WAIT_INIT;
              state     <= RAMW;
            end else begin
              if (!mem_w) begin
                Data_in <= per_rdata;
              end else begin
                if (hit_seg) seg_data <= Data_out;
                if (hit_sw)  led      <= Data_out[15:0];
              end
              state <= RESP;
            end
          end
        end
        RAMW: begin
          // Once the wait count is exhausted the RAM read data is valid on this edge
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            if (rd_q) Data_in <= ram_rdata;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running down-counter with sticky expiry interrupt; bus write beats decrement, expiry beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'h0;
      INT   <= 1'b0;
    end else begin
      if (cnt_wr)                count <= Data_out;
      else if (count != 32'h0)   count <= count - 32'h1;
      if (!cnt_wr && count == 32'h1) INT <= 1'b1;
      else if (int_clr)              INT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed scenarios plus randomized transactions.
// Latency: n/a (bench).
// Backpressure: n/a (bench drives one request at a time).
module tb_mio_bus_ctrl;

  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              CPU_MIO;
  logic              mem_w;
  logic [31:0]       Addr_out;
  logic [31:0]       Data_out;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [15:0]       sw;
  logic [15:0]       led;
  logic [31:0]       seg_data;
  logic              INT;

  mio_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .sw(sw), .led(led),
    .seg_data(seg_data), .INT(INT)
  );

  always #5 clk = ~clk;

  // Edge index: value after the n-th rising edge is sampled with cyc == n
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM device: synchronous read, one cycle after address
  logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:(1<<RAM_AW)-1];
  logic [31:0] m_seg, m_din;
  logic [15:0] m_led;
  // Counter modelled as a timeline: last load value/edge, pending expiry edge, last clear edge
  bit     has_load, pend;
  longint ld_v, ld_m, exp_edge, last_exp, last_clr;
  longint last_acc;

  task automatic model_reset();
    m_seg = 0; m_din = 0; m_led = 0;
    has_load = 0; pend = 0; ld_v = 0; ld_m = 0;
    exp_edge = 0; last_exp = -1; last_clr = -1;
  endtask

  function automatic logic [31:0] cnt_at(input longint k);
    if (!has_load || k < ld_m) return 32'h0;
    return (ld_v > k - ld_m) ? 32'(ld_v - (k - ld_m)) : 32'h0;
  endfunction

  function automatic logic int_at(input longint n);
    longint e;
    e = last_exp;
    if (pend && exp_edge <= n) e = exp_edge;
    return (e >= 0) && (e <= n) && (e >= last_clr);
  endfunction

  task automatic cnt_write(input longint m, input logic [31:0] v);
    if (pend && exp_edge < m) last_exp = exp_edge;
    has_load = 1; ld_v = longint'(v); ld_m = m;
    pend = (v != 0); exp_edge = m + longint'(v);
  endtask

  // kind: 0 RAM, 1 seg, 2 sw/led, 3 count, 4 INT, 5 unmapped
  function automatic int kind_of(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa < 32'h0000_1000)  return 0;
    if (wa == 32'hE000_0000) return 1;
    if (wa == 32'hF000_0000) return 2;
    if (wa == 32'hF000_0004) return 3;
    if (wa == 32'hF000_0008) return 4;
    return 5;
  endfunction

  // One complete bus transaction with all per-transaction checks
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d);
    longint acc;
    int kind, lat, we_n, exp_lat;
    logic [31:0] exp_rd, we_a, we_d;
    bit got;
    kind = kind_of(a);
    @(negedge clk);
    CPU_MIO = 1; mem_w = w; Addr_out = a; Data_out = d;
    acc = cyc + 1;
    last_acc = acc;
    case (kind)
      0: exp_rd = ref_mem[a[RAM_AW+1:2]];
      1: exp_rd = m_seg;
      2: exp_rd = {16'h0, sw};
      3: exp_rd = cnt_at(acc - 1);
      4: exp_rd = {31'h0, int_at(acc - 1)};
      default: exp_rd = 32'h0;
    endcase
    @(negedge clk);
    CPU_MIO = 0; mem_w = 0; Addr_out = $urandom; Data_out = $urandom;
    got = 0; we_n = 0; lat = 0; we_a = 0; we_d = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ram_we) begin we_n++; we_a = 32'(ram_addr); we_d = ram_wdata; end
      if (MIO_ready) begin got = 1; lat = int'(cyc - acc); end
      else @(negedge clk);
    end
    exp_lat = (kind == 0) ? RAM_WAIT + 2 : 1;
    if (got) check("latency", 32'(lat), 32'(exp_lat));
    else     check("ready_timeout", 32'h0, 32'h1);
    if (w) begin
      case (kind)
        0: ref_mem[a[RAM_AW+1:2]] = d;
        1: m_seg = d;
        2: m_led = d[15:0];
        3: cnt_write(acc, d);
        4: last_clr = acc;
        default: ;
      endcase
    end else begin
      m_din = exp_rd;
    end
    if (kind == 0 && w) begin
      check("ram_we_cnt", 32'(we_n), 32'd1);
      check("ram_addr", we_a, 32'(a[RAM_AW+1:2]));
      check("ram_wdata", we_d, d);
    end else begin
      check("ram_we_none", 32'(we_n), 32'd0);
    end
    check("data_in", Data_in, m_din);
    check("led", 32'(led), 32'(m_led));
    check("seg_data", seg_data, m_seg);
    check("int", 32'(INT), 32'(int_at(cyc)));
    @(negedge clk);
    check("ready_pulse_end", 32'(MIO_ready), 32'd0);
  endtask

  initial begin
    int sel, gap, b2b_pulses;
    longint acc;
    logic [31:0] a;
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    reset = 1; CPU_MIO = 0; mem_w = 0; Addr_out = 0; Data_out = 0; sw = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(MIO_ready), 32'd0);
    check("rst_data_in", Data_in, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_seg", seg_data, 32'd0);
    check("rst_int", 32'(INT), 32'd0);
    reset = 0;

    // RAM write then read back
    run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF);
    run_txn(0, 32'h0000_0010, 32'h0);
    check("ram_readback", Data_in, 32'hDEAD_BEEF);

    // Switch read and LED write
    sw = 16'h00A5;
    run_txn(0, 32'hF000_0000, 32'h0);
    check("sw_read", Data_in, 32'h0000_00A5);
    run_txn(1, 32'hF000_0000, 32'h1234_5678);
    check("led_write", 32'(led), 32'h5678);

    // Counter expiry timing, INT read and clear
    run_txn(1, 32'hF000_0004, 32'd5);
    acc = last_acc;
    while (cyc < acc + 4) @(negedge clk);
    check("int_before_expiry", 32'(INT), 32'd0);
    @(negedge clk);
    check("int_at_expiry", 32'(INT), 32'd1);
    run_txn(0, 32'hF000_0004, 32'h0);
    check("count_zero", Data_in, 32'd0);
    run_txn(0, 32'hF000_0008, 32'h0);
    check("int_read", Data_in, 32'd1);
    run_txn(1, 32'hF000_0008, 32'h0);
    check("int_cleared", 32'(INT), 32'd0);

    // Unmapped read/write
    run_txn(0, 32'h8000_0000, 32'h0);
    check("unmapped_read", Data_in, 32'd0);
    run_txn(1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back seg_data writes with CPU_MIO held high
    @(negedge clk);
    CPU_MIO = 1; mem_w = 1; Addr_out = 32'hE000_0000; Data_out = 32'h1;
    acc = cyc + 1;
    @(negedge clk);
    Data_out = 32'h2;
    b2b_pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("b2b_ready", 32'(MIO_ready), (i == 1 || i == 3) ? 32'd1 : 32'd0);
      if (MIO_ready) b2b_pulses++;
      if (i == 3) begin CPU_MIO = 0; mem_w = 0; end
    end
    check("b2b_pulses", 32'(b2b_pulses), 32'd2);
    check("b2b_seg", seg_data, 32'h2);
    m_seg = 32'h2;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      sw = 16'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = {20'h0, 10'($urandom), 2'($urandom)};
        3:       a = {30'h3800_0000, 2'($urandom)};
        4:       a = {30'h3C00_0000, 2'($urandom)};
        5, 6:    a = {30'h3C00_0001, 2'($urandom)};
        7:       a = {30'h3C00_0002, 2'($urandom)};
        default: a = {1'b1, 3'($urandom), 28'($urandom)};
      endcase
      if (sel == 5 || sel == 6) run_txn($urandom_range(0, 1) == 1, a, 32'($urandom_range(0, 12)));
      else                      run_txn($urandom_range(0, 1) == 1, a, $urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    // Reset in the middle of a RAM read
    run_txn(1, 32'hF000_0000, 32'h0000_FFFF);
    run_txn(1, 32'hE000_0000, 32'h0000_0055);
    run_txn(1, 32'hF000_0004, 32'd1);
    run_txn(0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    CPU_MIO = 1; mem_w = 0; Addr_out = 32'h0000_0020;
    @(negedge clk);
    CPU_MIO = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    b2b_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (MIO_ready || ram_we) b2b_pulses++;
    end
    check("abort_no_activity", 32'(b2b_pulses), 32'd0);
    check("abort_led", 32'(led), 32'd0);
    check("abort_seg", seg_data, 32'd0);
    check("abort_int", 32'(INT), 32'd0);
    check("abort_data_in", Data_in, 32'd0);
    run_txn(0, 32'hF000_0004, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
